// File: rtl/tetris_input_pkg.sv
// Shared definitions for the button-conditioning front end of the falling-piece block:
// button indices, per-button FSM encoding and counter width helper.
package tetris_input_pkg;

  localparam int NUM_BTN    = 4;
  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_ROTATE = 2;
  localparam int BTN_DOWN   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } btnState_t;

  // Width able to hold the terminal count n itself.
  function automatic int cntW(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce_repeat.sv
// One button: 2-FF synchronizer, counting debouncer and press/auto-repeat FSM.
// req is a combinational single-cycle request; the top registers it.
module btn_debounce_repeat
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic req
);

  localparam int DB_W  = cntW(DEBOUNCE_CYCLES);
  localparam int RPT_W = (cntW(REPEAT_DELAY) > cntW(REPEAT_RATE)) ? cntW(REPEAT_DELAY)
                                                                  : cntW(REPEAT_RATE);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [1:0]       syncQ;
  logic             deb;
  logic [DB_W-1:0]  dbCnt;
  btnState_t        state, stateNxt;
  logic [RPT_W-1:0] rptCnt, rptCntNxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      syncQ <= '0;
      deb   <= 1'b0;
      dbCnt <= '0;
    end else begin
      syncQ <= {syncQ[0], btn};
      if (syncQ[1] == deb) begin
        dbCnt <= '0;
      end else if (dbCnt == DB_LAST) begin
        deb   <= syncQ[1];
        dbCnt <= '0;
      end else begin
        dbCnt <= dbCnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rptCnt <= '0;
    end else begin
      state  <= stateNxt;
      rptCnt <= rptCntNxt;
    end
  end

  // A debounced release wins over everything, so no request can follow it.
  always_comb begin
    stateNxt  = state;
    rptCntNxt = rptCnt;
    req       = 1'b0;
    if (!deb) begin
      stateNxt  = IDLE;
      rptCntNxt = '0;
    end else begin
      case (state)
        IDLE: begin
          req       = 1'b1;
          rptCntNxt = '0;
          stateNxt  = REPEAT_EN ? DELAY : HELD;
        end
        DELAY: begin
          if (rptCnt == DELAY_LAST) begin
            req       = 1'b1;
            rptCntNxt = '0;
            stateNxt  = REPEAT;
          end else begin
            rptCntNxt = rptCnt + RPT_W'(1);
          end
        end
        REPEAT: begin
          if (rptCnt == RATE_LAST) begin
            req       = 1'b1;
            rptCntNxt = '0;
          end else begin
            rptCntNxt = rptCnt + RPT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/move_request_gen.sv
// Turns raw buttons plus a gravity timer into registered, one-hot, single-cycle move
// requests for the piece block, coalescing into one pending bit per output.
module move_request_gen
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int GRAVITY_PERIOD  = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_rotate,
  input  logic btn_down,
  input  logic enable,
  input  logic gravity_en,
  output logic leftSignal,
  output logic rightSignal,
  output logic upSignal,
  output logic downSignal
);

  localparam int GR_W = cntW(GRAVITY_PERIOD);
  localparam logic [GR_W-1:0] GR_LAST = GR_W'(GRAVITY_PERIOD - 1);

  logic [NUM_BTN-1:0] btnRaw, btnReq, pend, want, grant, moveQ;
  logic [GR_W-1:0]    grCnt;
  logic               grTick;

  assign btnRaw[BTN_LEFT]   = btn_left;
  assign btnRaw[BTN_RIGHT]  = btn_right;
  assign btnRaw[BTN_ROTATE] = btn_rotate;
  assign btnRaw[BTN_DOWN]   = btn_down;

  for (genvar i = 0; i < NUM_BTN; i++) begin : gBtn
    btn_debounce_repeat #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (i != BTN_ROTATE)
    ) uBtn (
      .clk   (clk),
      .reset (reset),
      .btn   (btnRaw[i]),
      .req   (btnReq[i])
    );
  end

  assign grTick = enable && gravity_en && (grCnt == GR_LAST);

  always_ff @(posedge clk) begin
    if (reset || !enable || !gravity_en) grCnt <= '0;
    else if (grCnt == GR_LAST)           grCnt <= '0;
    else                                 grCnt <= grCnt + GR_W'(1);
  end

  // Fixed priority rotate > left > right > down, same order the piece block uses.
  always_comb begin
    want           = pend | btnReq;
    want[BTN_DOWN] = want[BTN_DOWN] | grTick;
    grant          = '0;
    if      (want[BTN_ROTATE]) grant[BTN_ROTATE] = 1'b1;
    else if (want[BTN_LEFT])   grant[BTN_LEFT]   = 1'b1;
    else if (want[BTN_RIGHT])  grant[BTN_RIGHT]  = 1'b1;
    else if (want[BTN_DOWN])   grant[BTN_DOWN]   = 1'b1;
  end

  // Requests made while disabled are dropped rather than held for later.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pend  <= '0;
      moveQ <= '0;
    end else begin
      pend  <= want & ~grant;
      moveQ <= grant;
    end
  end

  assign leftSignal  = moveQ[BTN_LEFT];
  assign rightSignal = moveQ[BTN_RIGHT];
  assign upSignal    = moveQ[BTN_ROTATE];
  assign downSignal  = moveQ[BTN_DOWN];

endmodule

// File: tb/tb_move_request_gen.sv
// Directed bench for move_request_gen with small timing parameters; pulse edges are
// logged per output and compared against hand-derived edge lists.
module tb_move_request_gen;

  logic clk = 1'b0;
  logic reset, btn_left, btn_right, btn_rotate, btn_down, enable, gravity_en;
  logic leftSignal, rightSignal, upSignal, downSignal;
  logic [3:0] outs;

  always #5 clk = ~clk;

  move_request_gen #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3),
    .GRAVITY_PERIOD  (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_rotate  (btn_rotate),
    .btn_down    (btn_down),
    .enable      (enable),
    .gravity_en  (gravity_en),
    .leftSignal  (leftSignal),
    .rightSignal (rightSignal),
    .upSignal    (upSignal),
    .downSignal  (downSignal)
  );

  assign outs = {downSignal, upSignal, rightSignal, leftSignal};

  int nChk = 0;
  int nErr = 0;
  int ohBad = 0;
  int e = -1;
  int lq[$], rq[$], uq[$], dq[$], ex[$], none[$];

  task automatic chk(input string tag, input int got, input int want);
    nChk++;
    if (got != want) begin
      nErr++;
      $display("FAIL %s got %0d exp %0d", tag, got, want);
    end
  endtask

  task automatic chkq(input string tag, input int got[$], input int want[$]);
    chk({tag, "_n"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      chk(tag, (i < got.size()) ? got[i] : -1, want[i]);
  endtask

  // Edge e is the e-th rising edge after the scenario starts; outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    e++;
    if (leftSignal)  lq.push_back(e);
    if (rightSignal) rq.push_back(e);
    if (upSignal)    uq.push_back(e);
    if (downSignal)  dq.push_back(e);
    if ($countones(outs) > 1) ohBad++;
  endtask

  task automatic doReset();
    reset = 1'b1;
    {btn_left, btn_right, btn_rotate, btn_down} = '0;
    enable = 1'b1;
    gravity_en = 1'b0;
    repeat (3) step();
    chk("rst_outs", int'(outs), 0);
    reset = 1'b0;
    e = -1;
    lq.delete(); rq.delete(); uq.delete(); dq.delete();
  endtask

  initial begin
    reset = 1'b1;
    {btn_left, btn_right, btn_rotate, btn_down} = '0;
    enable = 1'b1;
    gravity_en = 1'b0;
    none.delete();

    // Held left: press at 7, first repeat 10 later, then every 3. Raw release at
    // edge 24 debounces low at edge 30, so 29 is the last pulse.
    doReset();
    btn_left = 1'b1;
    repeat (24) step();
    btn_left = 1'b0;
    repeat (21) step();
    ex = '{7, 17, 20, 23, 26, 29};
    chkq("s1_left", lq, ex);
    chkq("s1_right", rq, none);
    chkq("s1_up", uq, none);
    chkq("s1_down", dq, none);

    // Bouncing right never stays stable long enough to be accepted.
    doReset();
    for (int i = 0; i < 20; i++) begin
      btn_right = ((i / 2) % 2 == 0);
      step();
    end
    btn_right = 1'b0;
    repeat (20) step();
    chkq("s2_right", rq, none);

    // Rotate never repeats.
    doReset();
    btn_rotate = 1'b1;
    repeat (40) step();
    btn_rotate = 1'b0;
    repeat (20) step();
    ex = '{7};
    chkq("s3_up", uq, ex);
    chkq("s3_left", lq, none);

    // Simultaneous rotate+left: rotate first, left one edge later; left still
    // repeats at 17 since its debounced release only lands at 18.
    doReset();
    btn_left = 1'b1;
    btn_rotate = 1'b1;
    repeat (12) step();
    btn_left = 1'b0;
    btn_rotate = 1'b0;
    repeat (18) step();
    ex = '{7};
    chkq("s4_up", uq, ex);
    ex = '{8, 17};
    chkq("s4_left", lq, ex);

    // Gravity every 20 edges; a short down press lands on the first tick and merges.
    doReset();
    gravity_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      btn_down = (i >= 12 && i <= 17);
      step();
    end
    btn_down = 1'b0;
    gravity_en = 1'b0;
    ex = '{19, 39, 59, 79, 99};
    chkq("s5_down", dq, ex);

    // Reset during auto-repeat (sampled at edges 23,24) kills the edge-23 pulse;
    // still-held left re-presses 7 edges after reset drops (edge 25 -> 32).
    doReset();
    btn_left = 1'b1;
    for (int i = 0; i < 51; i++) begin
      reset = (i == 23 || i == 24);
      if (i == 34) btn_left = 1'b0;
      step();
      if (e == 23) chk("s6_rst_outs", int'(outs), 0);
    end
    ex = '{7, 17, 20, 32};
    chkq("s6_left", lq, ex);

    // Disabled during the press: the edge-7 pulse is dropped; repeats resume once enabled.
    doReset();
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 13) enable = 1'b1;
      btn_left = (i <= 18);
      step();
    end
    ex = '{17, 20, 23};
    chkq("s7_left", lq, ex);
    chkq("s7_up", uq, none);

    chk("onehot", ohBad, 0);
    $display("CHECKS %0d ERRORS %0d", nChk, nErr);
    $finish;
  end

endmodule
